// File: rtl/uart_receiver_if.sv
// uart_receiver_if: register-side bus between the UART receiver and its peripheral wrapper
//   rd_en     : one-cycle pulse, bus read of the RX data register
//   irq_en    : interrupt enable from the control register
//   rx_data   : last accepted byte
//   rx_valid  : rx_data holds an unread byte
//   frame_err : sticky, a stop bit was sampled low
//   overrun   : sticky, a byte was dropped because rx_valid was still set
//   rx_irq    : level interrupt, rx_valid & irq_en
interface uart_receiver_if;
  logic       rd_en;
  logic       irq_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_irq;
  modport master (
    output rd_en, irq_en,
    input  rx_data, rx_valid, frame_err, overrun, rx_irq
  );
  modport slave (
    input  rd_en, irq_en,
    output rx_data, rx_valid, frame_err, overrun, rx_irq
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with data register, sticky error flags and level interrupt
//   clk   : single clock, all state updates on posedge
//   reset : synchronous active-high reset
//   rx    : asynchronous serial line, idle high
//   bus   : register-side signals (uart_receiver_if.slave)
module uart_receiver #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  uart_receiver_if.slave   bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t          state, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic            line;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      idx, idx_d;
  logic [7:0]      shift, shift_d;
  logic            deliver, ferr, accept, rd_clr;
  logic [7:0]      data_q;
  logic            valid_q, ferr_q, ovr_q;
  // Synchronizer loads idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign line = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
    end
  end
  // Each wait counts down to 0; the line is sampled in the cycle the count is 0.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    shift_d = shift;
    deliver = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: if (!line) begin
        state_d = START;
        cnt_d   = HALF;
      end
      START: if (cnt == '0) begin
        state_d = line ? IDLE : DATA;
        idx_d   = '0;
        cnt_d   = FULL;
      end else cnt_d = cnt - 1'b1;
      DATA: if (cnt == '0) begin
        shift_d[idx] = line;
        cnt_d        = FULL;
        idx_d        = idx + 3'd1;
        state_d      = idx == 3'd7 ? STOP : DATA;
      end else cnt_d = cnt - 1'b1;
      STOP: if (cnt == '0) begin
        deliver = line;
        ferr    = !line;
        state_d = line ? IDLE : WAIT_IDLE;
      end else cnt_d = cnt - 1'b1;
      // A held-low line (break) must go high before a new start is accepted.
      WAIT_IDLE: state_d = line ? IDLE : WAIT_IDLE;
      default: state_d = IDLE;
    endcase
  end
  // A read in the delivery cycle frees the register for the new byte.
  assign accept = deliver && (!valid_q || bus.rd_en);
  assign rd_clr = bus.rd_en && !deliver;
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= accept ? shift : data_q;
      valid_q <= accept ? 1'b1 : rd_clr ? 1'b0 : valid_q;
      ferr_q  <= ferr ? 1'b1 : rd_clr ? 1'b0 : ferr_q;
      ovr_q   <= (deliver && !accept) ? 1'b1 : rd_clr ? 1'b0 : ovr_q;
    end
  end
  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.rx_irq    = valid_q & bus.irq_en;
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per UART bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of rx synchronizer flops; legal range 2..3.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port rd_en, input, 1 bit: one-cycle pulse from the peripheral bus read of the RX data register.
REQ-007 The block SHALL have port irq_en, input, 1 bit: interrupt enable from the peripheral control register.
REQ-008 The block SHALL have port rx_data, output, 8 bits: last accepted byte.
REQ-009 The block SHALL have port rx_valid, output, 1 bit: rx_data holds an unread byte.
REQ-010 The block SHALL have port frame_err, output, 1 bit: sticky flag, stop bit sampled low.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag, byte dropped because rx_valid was set.
REQ-012 The block SHALL have port rx_irq, output, 1 bit: level interrupt to the core, equal to rx_valid AND irq_en (combinational).

Function
REQ-013 rx SHALL pass through SYNC_STAGES flops before use; all references to "line" mean the synchronized value.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: on line==0, go to START and load the bit counter for a half-bit wait (CLKS_PER_BIT/2, integer floor).
REQ-016 START: at the end of the half-bit wait, sample line. If 0, go to DATA with bit_idx=0 and a full-bit wait. If 1 (glitch), return to IDLE with no flag change.
REQ-017 DATA: at each full-bit expiry, sample line into shift[bit_idx] (LSB first). After bit_idx 7, go to STOP with a full-bit wait.
REQ-018 STOP: at the full-bit expiry, sample line. If 1, deliver the byte and go to IDLE. If 0, discard the byte, set frame_err, and go to WAIT_IDLE.
REQ-019 WAIT_IDLE: stay until line==1 for one cycle, then go to IDLE (prevents a break from being read as repeated starts).
REQ-020 Baud counter SHALL count down from its load value to 0 and the sample SHALL occur in the cycle the count equals 0; counter width = clog2(CLKS_PER_BIT).
REQ-021 Delivery with rx_valid==0, or with rd_en asserted in the same cycle: rx_data <= shift and rx_valid <= 1 on the next edge; overrun unchanged.
REQ-022 Delivery with rx_valid==1 and rd_en==0: rx_data is retained, the new byte is dropped, and overrun <= 1.
REQ-023 rd_en without delivery SHALL clear rx_valid, frame_err and overrun on the next edge; rx_data holds its value.
REQ-024 Latency SHALL be: the rx_valid rise occurs at most SYNC_STAGES+1 cycles after the mid-stop-bit sample point.
REQ-025 rd_en while rx_valid==0 SHALL have no effect other than clearing the sticky flags.
REQ-026 A frame error in the same cycle as rd_en SHALL leave frame_err=1 (set wins over clear).

Reset
REQ-027 While reset is high at posedge clk: state=IDLE, counters=0, shift=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0; synchronizer flops load 1.
REQ-028 Reset mid-frame SHALL abort the frame with no delivery and no flag set; the next frame is received normally after reset falls, provided its start edge occurs after release.

Verification (CLKS_PER_BIT=16, SYNC_STAGES=2)
REQ-029 Send 0xA5 with a valid stop bit; response: rx_data=0xA5, rx_valid=1, rx_irq=1 with irq_en=1, and rx_irq=0 with irq_en=0. Pulse rd_en; response: rx_valid=0.
REQ-030 Drive a 5-cycle low glitch on rx; response: FSM returns to IDLE, rx_valid=0 and no flags set. Then send 0x3C; response: received correctly.
REQ-031 Send 0x11 then 0x22 with no read; response: rx_data=0x11, overrun=1. Then rd_en; response: overrun=0, rx_valid=0.
REQ-032 Send 0x7E with the stop bit low, holding rx low for 40 cycles; response: frame_err=1, rx_valid=0, and no spurious byte. Then send 0x55; response: rx_data=0x55.
REQ-033 Assert reset during bit 4 of a frame; response: all outputs 0 and rx_data=0x00. Then send 0xC3; response: rx_data=0xC3.
REQ-034 Assert rd_en in exactly the delivery cycle of a second byte 0x99 while rx_valid=1; response: rx_data=0x99, rx_valid=1, overrun=0.
